// File: rtl/name_pkg.sv
// Shared types and constants for the name-line field delta packer.
package name_pkg;

  // Field index width; covers up to 32 fields per record.
  localparam int IDX_W = 5;

  // Beat kind encoding on out_kind.
  localparam logic HDR = 1'b0;
  localparam logic FLD = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_FIELDS = 2'd2
  } state_t;

endpackage

// File: rtl/field_mask_scan.sv
// Combinational search for the lowest set mask bit at or above a start index.
// is_last reports that the bit found is also the highest set bit of the mask.
// start is one bit wider than an index so "one past the last field" is legal.
module field_mask_scan
  import name_pkg::*;
#(
  parameter int NUM_FIELDS = 10
) (
  input  logic [NUM_FIELDS-1:0] mask,
  input  logic [IDX_W:0]        start,
  output logic [IDX_W-1:0]      next_idx,
  output logic                  found,
  output logic                  is_last
);

  // Priority search from the top down so the lowest qualifying bit wins.
  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    is_last  = 1'b0;
    for (int k = NUM_FIELDS - 1; k >= 0; k--) begin
      if (mask[k] && (k >= int'(start))) begin
        next_idx = IDX_W'(k);
        found    = 1'b1;
      end
    end
    is_last = found;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      if (mask[k] && (k > int'(next_idx))) begin
        is_last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/name_field_delta_packer.sv
// Packs a record of fixed-width ASCII fields as a header mask of changed
// fields followed by one beat per changed field.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for a record; in_ready high, no output beat
//   ST_HEADER | presenting the change mask beat
//   ST_FIELDS | presenting changed field idx_q, lowest index first
module name_field_delta_packer
  import name_pkg::*;
#(
  parameter int NUM_FIELDS       = 10,
  parameter int FIELD_W          = 128,
  parameter int REFRESH_INTERVAL = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_FIELDS*FIELD_W-1:0] in_fields,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FIELD_W-1:0]            out_data,
  output logic                          out_kind,
  output logic [IDX_W-1:0]              out_idx,
  output logic                          out_last
);

  localparam int CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

  state_t                        state_q, state_d;
  // Holds the current record; it doubles as the reference for the next one.
  logic [NUM_FIELDS*FIELD_W-1:0] rec_q;
  logic                          prev_valid_q;
  logic [CNT_W-1:0]              rec_cnt_q;
  logic [NUM_FIELDS-1:0]         mask_q, mask_new;
  logic [IDX_W-1:0]              idx_q;
  logic                          last_q;
  logic                          accept, force_full;
  logic [IDX_W:0]                scan_start;
  logic [IDX_W-1:0]              scan_idx;
  logic                          scan_found, scan_last;

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;

  // Change mask of the incoming record against the stored one.
  always_comb begin
    force_full = !prev_valid_q || ((REFRESH_INTERVAL != 0) && (rec_cnt_q == '0));
    mask_new   = '0;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      mask_new[k] = force_full ||
                    (in_fields[k*FIELD_W +: FIELD_W] != rec_q[k*FIELD_W +: FIELD_W]);
    end
  end

  // From the header, search from bit 0; from a field beat, search above it.
  assign scan_start = (state_q == ST_FIELDS) ? ((IDX_W+1)'(idx_q) + (IDX_W+1)'(1)) : '0;

  field_mask_scan #(
    .NUM_FIELDS(NUM_FIELDS)
  ) u_scan (
    .mask    (mask_q),
    .start   (scan_start),
    .next_idx(scan_idx),
    .found   (scan_found),
    .is_last (scan_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; out_valid is high in both beat states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_HEADER;
      ST_HEADER: if (out_ready) state_d = scan_found ? ST_FIELDS : ST_IDLE;
      ST_FIELDS: if (out_ready && last_q) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Per-record control: mask capture, refresh counter, beat index walk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_valid_q <= 1'b0;
      rec_cnt_q    <= '0;
      mask_q       <= '0;
      idx_q        <= '0;
      last_q       <= 1'b0;
    end else begin
      if (accept) begin
        mask_q       <= mask_new;
        prev_valid_q <= 1'b1;
        if (REFRESH_INTERVAL != 0) begin
          rec_cnt_q <= (rec_cnt_q == CNT_W'(REFRESH_INTERVAL - 1)) ? '0 : rec_cnt_q + 1'b1;
        end
      end
      if (out_ready && ((state_q == ST_HEADER) || ((state_q == ST_FIELDS) && !last_q))) begin
        idx_q  <= scan_idx;
        last_q <= scan_last;
      end
    end
  end

  // Record storage needs no reset: prev_valid_q forces a full first record.
  always_ff @(posedge clk) begin
    if (accept) rec_q <= in_fields;
  end

  // Output beat decode; everything is zero outside the beat states.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_kind  = HDR;
    out_idx   = '0;
    out_last  = 1'b0;
    case (state_q)
      ST_HEADER: begin
        out_valid = 1'b1;
        out_data  = FIELD_W'(mask_q);
        out_last  = (mask_q == '0);
      end
      ST_FIELDS: begin
        out_valid = 1'b1;
        out_kind  = FLD;
        out_idx   = idx_q;
        out_data  = rec_q[idx_q*FIELD_W +: FIELD_W];
        out_last  = last_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/name_field_delta_packer.md
NAME_FIELD_DELTA_PACKER -- requirements
Module: name_field_delta_packer

Interface
REQ-001 SHALL have parameter NUM_FIELDS, default 10: number of name-line fields per record, range 2..32.
REQ-002 SHALL have parameter FIELD_W, default 128: width of each ASCII field, multiple of 8, minimum 32.
REQ-003 SHALL have parameter REFRESH_INTERVAL, default 0: force a full record every N records; 0 disables refresh.
REQ-004 SHALL have port clk  in  1: single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  in  1: a record is presented.
REQ-007 SHALL have port in_ready  out  1: the block accepts a record.
REQ-008 SHALL have port in_fields  in  NUM_FIELDS*FIELD_W: field k occupies bits [k*FIELD_W +: FIELD_W].
REQ-009 SHALL have port out_valid  out  1: an output beat is valid.
REQ-010 SHALL have port out_ready  in  1: the downstream consumer accepts the beat.
REQ-011 SHALL have port out_data  out  FIELD_W: header mask or field payload.
REQ-012 SHALL have port out_kind  out  1: 0 = header, 1 = field.
REQ-013 SHALL have port out_idx  out  5: field index of a field beat; 0 on a header.
REQ-014 SHALL have port out_last  out  1: marks the final beat of a record.

Function
REQ-015 SHALL implement FSM states IDLE, HEADER and FIELDS, with in_ready = (state == IDLE).
REQ-016 SHALL, on an in_valid && in_ready handshake, capture in_fields, compute mask[k] = (field k != stored prev[k]), write the captured record into prev, and move to HEADER on the next cycle.
REQ-017 SHALL force mask to all-ones for the first record after reset.
REQ-018 SHALL force mask to all-ones when REFRESH_INTERVAL != 0 and the record counter equals 0; the counter increments per accepted record and wraps from REFRESH_INTERVAL-1 to 0.
REQ-019 SHALL drive the HEADER beat as out_valid=1, out_kind=0, out_data = mask zero-extended, out_idx=0, and out_last=1 only if mask==0.
REQ-020 SHALL, on the HEADER handshake, go to IDLE if mask==0, else go to FIELDS with idx = the lowest set bit of mask.
REQ-021 SHALL drive each FIELDS beat as out_kind=1, out_idx=idx, out_data = captured field idx, and out_last=1 when idx is the highest set bit of mask.
REQ-022 SHALL, on a FIELDS handshake, advance idx to the next higher set bit, or go to IDLE after the last beat.
REQ-023 SHALL hold all out_* signals stable while out_valid && !out_ready (backpressure).
REQ-024 SHALL give a latency of 1 cycle from accept to header valid, and SHALL use 1+popcount(mask) beats per record.
REQ-025 SHALL assert in_ready in the cycle after the last beat handshake; it SHALL NOT accept a record in the same cycle as that handshake.
REQ-026 SHALL hold out_valid=0 in IDLE.

Reset
REQ-027 SHALL, while rst_n is low, set state=IDLE, out_valid=0, out_data=0, out_kind=0, out_idx=0, out_last=0, record counter=0, prev-valid flag=0, with prev contents don't-care.
REQ-028 SHALL, on reset mid-record, abort the record immediately with no further beats, and the next record SHALL be a full record.

Structure
REQ-029 SHALL define the state enum, the out_kind constants HDR=0 and FLD=1, and the index width in shared package name_pkg.
REQ-030 SHALL place next-set-bit search (input mask and start index; outputs next index, found, is_last) in sub-module field_mask_scan, which is combinational.

Verification
REQ-031 SHALL verify: reset, then record R0 = {"@HISEQ-MFG","461","C70PYACXX","8","1101","18260","2391 1","N","0","GCCAAT"} -> header mask 0x3FF, then 10 field beats with idx 0..9, out_last on idx 9.
REQ-032 SHALL verify: R0 repeated -> single header beat, mask 0x000, out_last=1.
REQ-033 SHALL verify: R0 with field 2 = "xxx" and field 7 = "xxx" -> header 0x084, beats idx 2 and 7, out_last on idx 7.
REQ-034 SHALL verify: out_ready held low for 3 cycles during beat idx 2 -> data and idx remain stable, no beat lost, in_ready stays 0.
REQ-035 SHALL verify: REFRESH_INTERVAL=4 with R0 sent 5 times -> masks 0x3FF, 0, 0, 0, 0x3FF.
REQ-036 SHALL verify: rst_n pulsed low during the FIELDS beat of idx 4, then R0 sent -> out_valid=0 within reset, then full mask 0x3FF.
